outlier_dot_engine: RTL and testbench
=====================================

OUTLIER_DOT_ENGINE -- requirements
Module: outlier_dot_engine

Interface
REQ-001 Parameter LANES, default 4, activation/weight pairs accepted per beat.
REQ-002 Parameter VEC_LEN, default 128, elements per dot product; SHALL be a multiple of LANES.
REQ-003 Parameter DW, default 16, signed fixed-point activation width.
REQ-004 Parameter FRAC, default 4, activation fractional bits.
REQ-005 Parameter WW, default 8, signed integer weight width.
REQ-006 Parameter QW, default 8, signed quantized-inlier width.
REQ-007 Parameter THRESH, default 100, outlier magnitude threshold in integer units.
REQ-008 Parameter MAX_OUT, default 4, outlier buffer depth.
REQ-009 Parameter ACC_W, default 40, int_acc width; SHALL be at least QW+WW+clog2(VEC_LEN).
REQ-010 clk  in  1  single clock, rising edge.
REQ-011 rst  in  1  synchronous, active-high reset.
REQ-012 start  in  1  begin new vector; sampled only in IDLE.
REQ-013 in_valid  in  1  act/wgt beat valid.
REQ-014 in_ready  out  1  beat accepted when in_valid and in_ready are both high.
REQ-015 act  in  LANES*DW  packed activations, lane 0 in the LSBs.
REQ-016 wgt  in  LANES*WW  packed weights, lane 0 in the LSBs.
REQ-017 out_valid  out  1  result valid.
REQ-018 out_ready  in  1  result consumed when out_valid and out_ready are both high.
REQ-019 int_acc  out  ACC_W  signed sum of quantized inlier products.
REQ-020 fp_acc  out  ACC_W+FRAC  signed full-precision outlier sum, FRAC fractional bits.
REQ-021 outlier_cnt  out  clog2(VEC_LEN+1)  count of elements classified as outliers.
REQ-022 outlier_ovf  out  1  outlier count exceeded MAX_OUT.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 FSM states: IDLE, RUN, DRAIN, DONE. IDLE goes to RUN on start. RUN goes to DRAIN after VEC_LEN/LANES beats. DRAIN goes to DONE when the buffer is empty. DONE goes to IDLE on the out handshake.
REQ-025 The start pulse SHALL clear int_acc, fp_acc, outlier_cnt, outlier_ovf and the buffer.
REQ-026 in_ready SHALL be high exactly while in RUN.
REQ-027 Classification: an element is an outlier when |act| > (THRESH<<FRAC); otherwise it is an inlier. The magnitude test SHALL apply to both signs.
REQ-028 Inlier quantization: q = act>>>FRAC (floor), saturated to the signed QW range. q*wgt SHALL be added to int_acc in the accepting cycle; all lanes SHALL be summed in that same cycle.
REQ-029 Outlier buffering: while the buffer holds fewer than MAX_OUT entries, the raw (act, wgt) pair SHALL be pushed. Multiple outliers in one beat SHALL be allocated in ascending lane order.
REQ-030 Outlier overflow: once the buffer is full, any further outlier SHALL be quantized to +(2^(QW-1)-1) if act>0, else -(2^(QW-1)). Its product SHALL go to int_acc, and outlier_ovf SHALL be set.
REQ-031 outlier_cnt SHALL count every outlier, buffered or clamped.
REQ-032 DRAIN SHALL pop one entry per cycle and add the full-precision act*wgt to fp_acc.
REQ-033 Latency: with the last beat accepted in cycle t and k entries buffered, out_valid SHALL rise in cycle t+2+k.
REQ-034 In DONE, all outputs SHALL hold stable until out_ready is high. The cycle after the handshake, state SHALL be IDLE and out_valid SHALL be 0.
REQ-035 start outside IDLE SHALL be ignored. in_valid outside RUN SHALL be ignored.
REQ-036 int_acc and fp_acc SHALL not wrap within the parameter rule of REQ-009.

Reset
REQ-037 When rst is high at a clock edge, the state SHALL become IDLE and in_ready, out_valid, busy and outlier_ovf SHALL be 0.
REQ-038 Reset SHALL clear int_acc, fp_acc, outlier_cnt, the beat counter and the buffer, and SHALL discard any in-flight vector.
REQ-039 rst SHALL take priority over start and over both handshakes.

Configuration
REQ-040 Macro ODE_ROUND_EN: when defined, inlier quantization SHALL be (act + (1<<(FRAC-1)))>>>FRAC, round-half-up, then saturated. When undefined, quantization SHALL floor as in REQ-028.

Verification
REQ-041 All act=0x0020 (2.0), wgt=3, defaults -> int_acc=768, fp_acc=0, outlier_cnt=0, out_valid at t+2.
REQ-042 Element 5 act=0x0C80 (200.0), wgt=2, all others 0 -> fp_acc=0x1900 (400.0), outlier_cnt=1, out_valid at t+3.
REQ-043 Six elements act=0x0960 (150.0), wgt=1, others 0 -> fp_acc=600.0, int_acc=254, outlier_cnt=6, outlier_ovf=1.
REQ-044 One element act=0x0028 (2.5), wgt=1, others 0 -> int_acc=2 without ODE_ROUND_EN, 3 with it.
REQ-045 Hold out_ready=0 for 5 cycles in DONE -> out_valid and all results stable; handshake -> IDLE on the next cycle.
REQ-046 Assert rst for 1 cycle after 10 RUN beats -> IDLE, outputs 0; a new start then yields the correct result for a fresh vector.

Source files
------------

// File: rtl/outlier_dot_engine.sv
// rtl/outlier_dot_engine.sv - streaming dot product with quantized inliers and full-precision outlier side path
// Define ODE_ROUND_EN for round-half-up inlier quantization; floor quantization otherwise.
module outlier_dot_engine #(
  parameter int LANES   = 4,
  parameter int VEC_LEN = 128,
  parameter int DW      = 16,
  parameter int FRAC    = 4,
  parameter int WW      = 8,
  parameter int QW      = 8,
  parameter int THRESH  = 100,
  parameter int MAX_OUT = 4,
  parameter int ACC_W   = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DW-1:0]          act,
  input  logic [LANES*WW-1:0]          wgt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_W-1:0]      int_acc,
  output logic signed [ACC_W+FRAC-1:0] fp_acc,
  output logic [$clog2(VEC_LEN+1)-1:0] outlier_cnt,
  output logic                         outlier_ovf,
  output logic                         busy
);
  localparam int BEATS = VEC_LEN / LANES;
  localparam int BCW   = $clog2(BEATS + 1);
  localparam int CW    = $clog2(VEC_LEN + 1);
  localparam int BW    = $clog2(MAX_OUT + 1);
  localparam int AW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int LCW   = $clog2(LANES + 1);
  localparam int PW    = QW + WW;
  localparam int FW    = DW + WW;
  localparam int FAW   = ACC_W + FRAC;

  localparam logic signed [DW:0] THR_FX = (DW+1)'(THRESH << FRAC);
  localparam logic signed [DW:0] Q_HI   = (DW+1)'((1 << (QW-1)) - 1);
  localparam logic signed [DW:0] Q_LO   = -(DW+1)'(1 << (QW-1));
`ifdef ODE_ROUND_EN
  localparam logic signed [DW:0] RND    = (DW+1)'(1 << (FRAC-1));
`else
  localparam logic signed [DW:0] RND    = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [BCW-1:0]          r_beat;
  logic [BW-1:0]           r_wr_cnt, r_rd_ptr;
  logic [DW-1:0]           r_buf_act [MAX_OUT];
  logic [WW-1:0]           r_buf_wgt [MAX_OUT];
  logic signed [ACC_W-1:0] r_int_acc;
  logic signed [FAW-1:0]   r_fp_acc;
  logic [CW-1:0]           r_cnt;
  logic                    r_ovf;

  logic                    w_accept, w_last, w_empty;
  logic signed [ACC_W-1:0] w_beat_sum;
  logic [LCW-1:0]          w_beat_cnt;
  logic                    w_beat_ovf;
  logic [BW-1:0]           w_fill;
  logic [LANES-1:0]        w_push;
  logic [BW-1:0]           w_slot [LANES];
  logic signed [DW-1:0]    w_pop_a;
  logic signed [WW-1:0]    w_pop_w;
  logic signed [FW-1:0]    w_pop_p;

  assign w_accept = in_valid && (r_state == S_RUN);
  assign w_last   = (r_beat == BCW'(BEATS - 1));
  assign w_empty  = (r_rd_ptr == r_wr_cnt);

  // Outliers claim buffer slots in ascending lane order; once full they fall back to clamped integer products.
  always_comb begin : lane_proc
    logic signed [DW-1:0] w_a;
    logic signed [WW-1:0] w_w;
    logic signed [DW:0]   w_ext, w_abs, w_q;
    logic signed [QW-1:0] w_qs;
    logic signed [PW-1:0] w_p;
    w_beat_sum = '0;
    w_beat_cnt = '0;
    w_beat_ovf = 1'b0;
    w_fill     = r_wr_cnt;
    w_push     = '0;
    for (int l = 0; l < LANES; l++) begin
      w_a   = act[l*DW +: DW];
      w_w   = wgt[l*WW +: WW];
      w_ext = {w_a[DW-1], w_a};
      w_abs = w_a[DW-1] ? -w_ext : w_ext;
      w_q   = (w_ext + RND) >>> FRAC;
      if (w_q > Q_HI)      w_qs = Q_HI[QW-1:0];
      else if (w_q < Q_LO) w_qs = Q_LO[QW-1:0];
      else                 w_qs = w_q[QW-1:0];
      w_slot[l] = '0;
      if (w_abs > THR_FX) begin
        w_beat_cnt = w_beat_cnt + LCW'(1);
        if (w_fill < BW'(MAX_OUT)) begin
          w_push[l] = 1'b1;
          w_slot[l] = w_fill;
          w_fill    = w_fill + BW'(1);
          w_qs      = '0;
        end else begin
          w_beat_ovf = 1'b1;
          w_qs       = w_a[DW-1] ? Q_LO[QW-1:0] : Q_HI[QW-1:0];
        end
      end
      w_p        = w_qs * w_w;
      w_beat_sum = w_beat_sum + ACC_W'(w_p);
    end
  end

  assign w_pop_a = r_buf_act[r_rd_ptr[AW-1:0]];
  assign w_pop_w = r_buf_wgt[r_rd_ptr[AW-1:0]];
  assign w_pop_p = w_pop_a * w_pop_w;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_empty) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat    <= '0;
      r_wr_cnt  <= '0;
      r_rd_ptr  <= '0;
      r_int_acc <= '0;
      r_fp_acc  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_beat    <= '0;
          r_wr_cnt  <= '0;
          r_rd_ptr  <= '0;
          r_int_acc <= '0;
          r_fp_acc  <= '0;
          r_cnt     <= '0;
          r_ovf     <= 1'b0;
        end
        S_RUN: if (w_accept) begin
          r_beat    <= r_beat + BCW'(1);
          r_wr_cnt  <= w_fill;
          r_int_acc <= r_int_acc + w_beat_sum;
          r_cnt     <= r_cnt + CW'(w_beat_cnt);
          if (w_beat_ovf) r_ovf <= 1'b1;
        end
        S_DRAIN: if (!w_empty) begin
          r_rd_ptr <= r_rd_ptr + BW'(1);
          r_fp_acc <= r_fp_acc + FAW'(w_pop_p);
        end
        default: ;
      endcase
    end
  end

  // Buffer contents need no reset: the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (!rst && w_accept && w_push[l]) begin
        r_buf_act[w_slot[l][AW-1:0]] <= act[l*DW +: DW];
        r_buf_wgt[w_slot[l][AW-1:0]] <= wgt[l*WW +: WW];
      end
    end
  end

  assign in_ready    = (r_state == S_RUN);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign int_acc     = r_int_acc;
  assign fp_acc      = r_fp_acc;
  assign outlier_cnt = r_cnt;
  assign outlier_ovf = r_ovf;
endmodule

// File: tb/tb_outlier_dot_engine.sv
// tb/tb_outlier_dot_engine.sv - directed self-checking bench for outlier_dot_engine
module tb_outlier_dot_engine;
  localparam int LANES   = 4;
  localparam int VEC_LEN = 128;
  localparam int BEATS   = VEC_LEN / LANES;

  logic               clk = 1'b0;
  logic               rst, start, in_valid, out_ready;
  logic [LANES*16-1:0] act;
  logic [LANES*8-1:0]  wgt;
  logic               in_ready, out_valid, outlier_ovf, busy;
  logic signed [39:0] int_acc;
  logic signed [43:0] fp_acc;
  logic [7:0]         outlier_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat;
  logic [15:0] va [VEC_LEN];
  logic [7:0]  vw [VEC_LEN];

  outlier_dot_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
    .int_acc(int_acc), .fp_acc(fp_acc), .outlier_cnt(outlier_cnt),
    .outlier_ovf(outlier_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clr_vec();
    for (int i = 0; i < VEC_LEN; i++) begin
      va[i] = 16'h0000;
      vw[i] = 8'h00;
    end
  endtask

  task automatic drive_beat(input int b);
    for (int l = 0; l < LANES; l++) begin
      act[l*16 +: 16] = va[b*LANES + l];
      wgt[l*8 +: 8]   = vw[b*LANES + l];
    end
  endtask

  // Latency is counted from the cycle the last beat is presented to the first cycle out_valid is high.
  task automatic run_vec(output int lat_o);
    int t_last;
    t_last = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      if (b == 0) chk("in_ready_run", in_ready, 1);
      if (b == BEATS - 1) t_last = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat_o = -1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        lat_o = cyc - t_last;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; act = '0; wgt = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", outlier_ovf, 0);
    chk("rst_int", int_acc, 0);
    chk("rst_fp", fp_acc, 0);
    chk("rst_cnt", outlier_cnt, 0);
    rst = 1'b0;

    // all-inlier vector; beats offered while idle must be ignored
    clr_vec();
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 16'h0020; vw[i] = 8'd3; end
    drive_beat(0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    run_vec(lat);
    chk("v1_int", int_acc, 768);
    chk("v1_fp", fp_acc, 0);
    chk("v1_cnt", outlier_cnt, 0);
    chk("v1_ovf", outlier_ovf, 0);
    chk("v1_lat", lat, 2);
    handshake();

    // single buffered outlier, then DONE hold with out_ready low
    clr_vec();
    va[5] = 16'h0C80; vw[5] = 8'd2;
    run_vec(lat);
    chk("v2_fp", fp_acc, 6400);
    chk("v2_int", int_acc, 0);
    chk("v2_cnt", outlier_cnt, 1);
    chk("v2_lat", lat, 3);
    in_valid = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_fp", fp_acc, 6400);
      chk("hold_int", int_acc, 0);
      chk("hold_cnt", outlier_cnt, 1);
    end
    in_valid = 1'b0; start = 1'b0;
    handshake();

    // six outliers: four buffered, two clamped to +127
    clr_vec();
    for (int i = 0; i < 6; i++) begin va[i] = 16'h0960; vw[i] = 8'd1; end
    run_vec(lat);
    chk("v3_fp", fp_acc, 9600);
    chk("v3_int", int_acc, 254);
    chk("v3_cnt", outlier_cnt, 6);
    chk("v3_ovf", outlier_ovf, 1);
    chk("v3_lat", lat, 6);
    handshake();

    // half-LSB inlier: floor vs round-half-up
    clr_vec();
    va[0] = 16'h0028; vw[0] = 8'd1;
    run_vec(lat);
`ifdef ODE_ROUND_EN
    chk("v4_int", int_acc, 3);
`else
    chk("v4_int", int_acc, 2);
`endif
    chk("v4_fp", fp_acc, 0);
    chk("v4_ovf", outlier_ovf, 0);
    chk("v4_lat", lat, 2);
    handshake();

    // threshold edges, negative values and negative clamp
    clr_vec();
    va[0] = 16'h0640; vw[0] = 8'd1;
    va[1] = 16'hF9C0; vw[1] = 8'd2;
    va[2] = 16'hFFF8; vw[2] = 8'd5;
    for (int i = 3; i < 8; i++) begin va[i] = 16'hF6A0; vw[i] = 8'd2; end
    va[8] = 16'h0641; vw[8] = 8'd1;
    run_vec(lat);
`ifdef ODE_ROUND_EN
    chk("v5_int", int_acc, -229);
`else
    chk("v5_int", int_acc, -234);
`endif
    chk("v5_fp", fp_acc, -19200);
    chk("v5_cnt", outlier_cnt, 6);
    chk("v5_ovf", outlier_ovf, 1);
    chk("v5_lat", lat, 6);
    handshake();

    // reset after ten beats of a vector that filled the buffer
    clr_vec();
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 16'h0960; vw[i] = 8'd1; end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_ovf", outlier_ovf, 0);
    chk("mid_int", int_acc, 0);
    chk("mid_fp", fp_acc, 0);
    chk("mid_cnt", outlier_cnt, 0);
    clr_vec();
    va[5] = 16'h0C80; vw[5] = 8'd2;
    run_vec(lat);
    chk("v6_fp", fp_acc, 6400);
    chk("v6_int", int_acc, 0);
    chk("v6_cnt", outlier_cnt, 1);
    chk("v6_ovf", outlier_ovf, 0);
    chk("v6_lat", lat, 3);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
